// File: rtl/memory_arbiter_pkg.sv
// rtl/memory_arbiter_pkg.sv - widths, PROT constants, FSM states and request priority for the memory arbiter
package memory_arbiter_pkg;

  localparam int AXI_ADDR_WIDTH   = 32;
  localparam int AXI_DATA_WIDTH   = 32;
  localparam int AXI_STROBE_WIDTH = AXI_DATA_WIDTH / 8;

  localparam logic [2:0] PROT_INSTR = 3'b100;
  localparam logic [2:0] PROT_DATA  = 3'b000;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_AW_W,
    ST_B,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    REQ_NONE,
    REQ_STORE,
    REQ_LOAD,
    REQ_FETCH
  } req_t;

  // Data accesses beat fetch; a store wins over a simultaneous load.
  function automatic req_t pick_request(input logic we, input logic re, input logic pv);
    req_t req;
    if (we) begin
      req = REQ_STORE;
    end else if (re) begin
      req = REQ_LOAD;
    end else if (pv) begin
      req = REQ_FETCH;
    end else begin
      req = REQ_NONE;
    end
    return req;
  endfunction

endpackage

// File: rtl/memory_arbiter_if.sv
// rtl/memory_arbiter_if.sv - AXI4-Lite bus between the arbiter (master) and memory (slave)
interface memory_arbiter_if;
  import memory_arbiter_pkg::*;

  logic                        awvalid;
  logic                        awready;
  logic [AXI_ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]                  awprot;

  logic                        wvalid;
  logic                        wready;
  logic [AXI_DATA_WIDTH-1:0]   wdata;
  logic [AXI_STROBE_WIDTH-1:0] wstrb;

  logic                        bvalid;
  logic                        bready;
  logic [1:0]                  bresp;

  logic                        arvalid;
  logic                        arready;
  logic [AXI_ADDR_WIDTH-1:0]   araddr;
  logic [2:0]                  arprot;

  logic                        rvalid;
  logic                        rready;
  logic [AXI_DATA_WIDTH-1:0]   rdata;
  logic [1:0]                  rresp;

  modport master (
    output awvalid, awaddr, awprot,
    input  awready,
    output wvalid, wdata, wstrb,
    input  wready,
    input  bvalid, bresp,
    output bready,
    output arvalid, araddr, arprot,
    input  arready,
    input  rvalid, rdata, rresp,
    output rready
  );

  modport slave (
    input  awvalid, awaddr, awprot,
    output awready,
    input  wvalid, wdata, wstrb,
    output wready,
    output bvalid, bresp,
    input  bready,
    input  arvalid, araddr, arprot,
    output arready,
    output rvalid, rdata, rresp,
    input  rready
  );

endinterface

// File: rtl/memory_arbiter.sv
// rtl/memory_arbiter.sv - single AXI4-Lite master serialising rv32i fetch, load and store requests
// Optional MEMORY_ARBITER_BUS_ERR_EN adds o_bus_error, pulsed with the done valid on a non-OKAY response.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int ADDR_W = AXI_ADDR_WIDTH,
  parameter int DATA_W = AXI_DATA_WIDTH,
  parameter int STRB_W = DATA_W / 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  memory_arbiter_if.master  m_axi,
  input  logic [ADDR_W-1:0] i_pc,
  input  logic              i_pc_valid,
  output logic [DATA_W-1:0] o_instruction,
  output logic              o_instruction_valid,
  input  logic [ADDR_W-1:0] i_read_write_addr,
  input  logic [DATA_W-1:0] i_write_data,
  input  logic              i_read_enable,
  input  logic              i_write_enable,
  input  logic [STRB_W-1:0] i_write_strobe,
  output logic [DATA_W-1:0] o_read_data,
  output logic              o_read_write_valid
`ifdef MEMORY_ARBITER_BUS_ERR_EN
  ,
  output logic              o_bus_error
`endif
);

  state_t            r_state,       w_state_nxt;
  logic              r_is_fetch,    w_is_fetch_nxt;

  logic              r_arvalid,     w_arvalid_nxt;
  logic [ADDR_W-1:0] r_araddr,      w_araddr_nxt;
  logic [2:0]        r_arprot,      w_arprot_nxt;
  logic              r_rready,      w_rready_nxt;

  logic              r_awvalid,     w_awvalid_nxt;
  logic [ADDR_W-1:0] r_awaddr,      w_awaddr_nxt;
  logic [2:0]        r_awprot,      w_awprot_nxt;
  logic              r_wvalid,      w_wvalid_nxt;
  logic [DATA_W-1:0] r_wdata,       w_wdata_nxt;
  logic [STRB_W-1:0] r_wstrb,       w_wstrb_nxt;
  logic              r_bready,      w_bready_nxt;

  logic [DATA_W-1:0] r_instruction, w_instruction_nxt;
  logic              r_instr_valid, w_instr_valid_nxt;
  logic [DATA_W-1:0] r_read_data,   w_read_data_nxt;
  logic              r_rw_valid,    w_rw_valid_nxt;

`ifdef MEMORY_ARBITER_BUS_ERR_EN
  logic              r_bus_error,   w_bus_error_nxt;
`else
  logic              w_unused_resp;
  assign w_unused_resp = &{1'b0, m_axi.rresp, m_axi.bresp};
`endif

  logic w_ar_hs;
  logic w_r_hs;
  logic w_aw_hs;
  logic w_w_hs;
  logic w_b_hs;
  logic w_aw_done;
  logic w_w_done;
  req_t w_req;

  assign w_ar_hs   = r_arvalid & m_axi.arready;
  assign w_r_hs    = r_rready  & m_axi.rvalid;
  assign w_aw_hs   = r_awvalid & m_axi.awready;
  assign w_w_hs    = r_wvalid  & m_axi.wready;
  assign w_b_hs    = r_bready  & m_axi.bvalid;
  // A store channel counts as done if it was accepted earlier or is being accepted now.
  assign w_aw_done = ~r_awvalid | w_aw_hs;
  assign w_w_done  = ~r_wvalid  | w_w_hs;
  assign w_req     = pick_request(i_write_enable, i_read_enable, i_pc_valid);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_is_fetch    <= 1'b0;
      r_arvalid     <= 1'b0;
      r_araddr      <= '0;
      r_arprot      <= '0;
      r_rready      <= 1'b0;
      r_awvalid     <= 1'b0;
      r_awaddr      <= '0;
      r_awprot      <= '0;
      r_wvalid      <= 1'b0;
      r_wdata       <= '0;
      r_wstrb       <= '0;
      r_bready      <= 1'b0;
      r_instruction <= '0;
      r_instr_valid <= 1'b0;
      r_read_data   <= '0;
      r_rw_valid    <= 1'b0;
`ifdef MEMORY_ARBITER_BUS_ERR_EN
      r_bus_error   <= 1'b0;
`endif
    end else begin
      r_state       <= w_state_nxt;
      r_is_fetch    <= w_is_fetch_nxt;
      r_arvalid     <= w_arvalid_nxt;
      r_araddr      <= w_araddr_nxt;
      r_arprot      <= w_arprot_nxt;
      r_rready      <= w_rready_nxt;
      r_awvalid     <= w_awvalid_nxt;
      r_awaddr      <= w_awaddr_nxt;
      r_awprot      <= w_awprot_nxt;
      r_wvalid      <= w_wvalid_nxt;
      r_wdata       <= w_wdata_nxt;
      r_wstrb       <= w_wstrb_nxt;
      r_bready      <= w_bready_nxt;
      r_instruction <= w_instruction_nxt;
      r_instr_valid <= w_instr_valid_nxt;
      r_read_data   <= w_read_data_nxt;
      r_rw_valid    <= w_rw_valid_nxt;
`ifdef MEMORY_ARBITER_BUS_ERR_EN
      r_bus_error   <= w_bus_error_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_is_fetch_nxt    = r_is_fetch;
    w_arvalid_nxt     = r_arvalid;
    w_araddr_nxt      = r_araddr;
    w_arprot_nxt      = r_arprot;
    w_rready_nxt      = r_rready;
    w_awvalid_nxt     = r_awvalid;
    w_awaddr_nxt      = r_awaddr;
    w_awprot_nxt      = r_awprot;
    w_wvalid_nxt      = r_wvalid;
    w_wdata_nxt       = r_wdata;
    w_wstrb_nxt       = r_wstrb;
    w_bready_nxt      = r_bready;
    w_instruction_nxt = r_instruction;
    w_instr_valid_nxt = 1'b0;
    w_read_data_nxt   = r_read_data;
    w_rw_valid_nxt    = 1'b0;
`ifdef MEMORY_ARBITER_BUS_ERR_EN
    w_bus_error_nxt   = 1'b0;
`endif

    case (r_state)
      ST_IDLE: begin
        case (w_req)
          REQ_STORE: begin
            w_awaddr_nxt  = i_read_write_addr;
            w_awprot_nxt  = PROT_DATA;
            w_wdata_nxt   = i_write_data;
            w_wstrb_nxt   = i_write_strobe;
            w_awvalid_nxt = 1'b1;
            w_wvalid_nxt  = 1'b1;
            w_state_nxt   = ST_AW_W;
          end
          REQ_LOAD: begin
            w_araddr_nxt   = i_read_write_addr;
            w_arprot_nxt   = PROT_DATA;
            w_arvalid_nxt  = 1'b1;
            w_is_fetch_nxt = 1'b0;
            w_state_nxt    = ST_AR;
          end
          REQ_FETCH: begin
            w_araddr_nxt   = i_pc;
            w_arprot_nxt   = PROT_INSTR;
            w_arvalid_nxt  = 1'b1;
            w_is_fetch_nxt = 1'b1;
            w_state_nxt    = ST_AR;
          end
          default: begin
          end
        endcase
      end

      ST_AR: begin
        if (w_ar_hs) begin
          w_arvalid_nxt = 1'b0;
          w_rready_nxt  = 1'b1;
          w_state_nxt   = ST_R;
        end
      end

      ST_R: begin
        if (w_r_hs) begin
          w_rready_nxt = 1'b0;
          if (r_is_fetch) begin
            w_instruction_nxt = m_axi.rdata;
            w_instr_valid_nxt = 1'b1;
          end else begin
            w_read_data_nxt = m_axi.rdata;
            w_rw_valid_nxt  = 1'b1;
          end
`ifdef MEMORY_ARBITER_BUS_ERR_EN
          w_bus_error_nxt = (m_axi.rresp != RESP_OKAY);
`endif
          w_state_nxt = ST_DONE;
        end
      end

      ST_AW_W: begin
        if (w_aw_hs) begin
          w_awvalid_nxt = 1'b0;
        end
        if (w_w_hs) begin
          w_wvalid_nxt = 1'b0;
        end
        if (w_aw_done && w_w_done) begin
          w_bready_nxt = 1'b1;
          w_state_nxt  = ST_B;
        end
      end

      ST_B: begin
        if (w_b_hs) begin
          w_bready_nxt   = 1'b0;
          w_rw_valid_nxt = 1'b1;
`ifdef MEMORY_ARBITER_BUS_ERR_EN
          w_bus_error_nxt = (m_axi.bresp != RESP_OKAY);
`endif
          w_state_nxt = ST_DONE;
        end
      end

      // One dead cycle lets the core drop the request it just had serviced.
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign m_axi.arvalid = r_arvalid;
  assign m_axi.araddr  = r_araddr;
  assign m_axi.arprot  = r_arprot;
  assign m_axi.rready  = r_rready;
  assign m_axi.awvalid = r_awvalid;
  assign m_axi.awaddr  = r_awaddr;
  assign m_axi.awprot  = r_awprot;
  assign m_axi.wvalid  = r_wvalid;
  assign m_axi.wdata   = r_wdata;
  assign m_axi.wstrb   = r_wstrb;
  assign m_axi.bready  = r_bready;

  assign o_instruction       = r_instruction;
  assign o_instruction_valid = r_instr_valid;
  assign o_read_data         = r_read_data;
  assign o_read_write_valid  = r_rw_valid;
`ifdef MEMORY_ARBITER_BUS_ERR_EN
  assign o_bus_error         = r_bus_error;
`endif

endmodule

// File: tb/tb_memory_arbiter.sv
// tb/tb_memory_arbiter.sv - scoreboard bench for memory_arbiter: fetch, load, store, contention, abort
module tb_memory_arbiter;
  import memory_arbiter_pkg::*;

  typedef struct {
    bit          is_fetch;
    logic [31:0] data;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        pc_valid;
  logic [31:0] instruction;
  logic        instruction_valid;
  logic [31:0] rw_addr;
  logic [31:0] write_data;
  logic        read_enable;
  logic        write_enable;
  logic [3:0]  write_strobe;
  logic [31:0] read_data;
  logic        read_write_valid;
`ifdef MEMORY_ARBITER_BUS_ERR_EN
  logic        bus_error;
`endif

  int          n_vectors;
  int          n_miscompares;
  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] model_rdata;
  logic        prev_pulse;

  memory_arbiter_if bus ();

  memory_arbiter dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .m_axi               (bus),
    .i_pc                (pc),
    .i_pc_valid          (pc_valid),
    .o_instruction       (instruction),
    .o_instruction_valid (instruction_valid),
    .i_read_write_addr   (rw_addr),
    .i_write_data        (write_data),
    .i_read_enable       (read_enable),
    .i_write_enable      (write_enable),
    .i_write_strobe      (write_strobe),
    .o_read_data         (read_data),
    .o_read_write_valid  (read_write_valid)
`ifdef MEMORY_ARBITER_BUS_ERR_EN
    ,
    .o_bus_error         (bus_error)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input bit is_fetch, input logic [31:0] data);
    exp_t e;
    e.is_fetch = is_fetch;
    if (!is_fetch) model_rdata = data;
    e.data = is_fetch ? data : model_rdata;
    exp_q.push_back(e);
  endtask

  task automatic push_store();
    exp_t e;
    e.is_fetch = 1'b0;
    e.data     = model_rdata;
    exp_q.push_back(e);
  endtask

  // Pop the scoreboard on every done pulse; the pulse must never be two cycles wide.
  always @(negedge clk) begin
    if (rst) begin
      prev_pulse <= 1'b0;
    end else begin
      if (instruction_valid || read_write_valid) begin
        check_vec("pulse_width", {31'b0, prev_pulse}, 32'd0);
        if (exp_q.size() == 0) begin
          check_vec("sb_unexpected", {30'b0, instruction_valid, read_write_valid}, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check_vec("sb_kind", {30'b0, instruction_valid, read_write_valid},
                    mon_e.is_fetch ? 32'd2 : 32'd1);
          if (mon_e.is_fetch) check_vec("sb_instr", instruction, mon_e.data);
          else                check_vec("sb_rdata", read_data, mon_e.data);
        end
      end
      if (bus.arvalid || bus.awvalid)
        check_vec("ar_aw_excl", {31'b0, bus.arvalid & bus.awvalid}, 32'd0);
      prev_pulse <= instruction_valid | read_write_valid;
    end
  end

  task automatic wait_ar(input string tag, input int budget);
    int n = 0;
    while (!bus.arvalid && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_vec(tag, {31'b0, bus.arvalid}, 32'd1);
  endtask

  task automatic r_complete(input bit is_fetch, input logic [31:0] addr, input logic [31:0] data,
                            input int ar_d, input int r_d);
    for (int i = 0; i < ar_d; i++) begin
      @(negedge clk);
      check_vec("ar_hold_valid", {31'b0, bus.arvalid}, 32'd1);
      check_vec("ar_hold_addr", bus.araddr, addr);
    end
    bus.arready = 1'b1;
    @(negedge clk);
    bus.arready = 1'b0;
    check_vec("ar_drop", {31'b0, bus.arvalid}, 32'd0);
    check_vec("rready_up", {31'b0, bus.rready}, 32'd1);
    for (int i = 0; i < r_d; i++) begin
      @(negedge clk);
      check_vec("rready_hold", {31'b0, bus.rready}, 32'd1);
    end
    bus.rvalid = 1'b1;
    bus.rdata  = data;
    bus.rresp  = 2'b00;
    @(negedge clk);
    bus.rvalid = 1'b0;
    bus.rdata  = $urandom;
    check_vec("rready_drop", {31'b0, bus.rready}, 32'd0);
    check_vec("done_pulse", {31'b0, is_fetch ? instruction_valid : read_write_valid}, 32'd1);
    @(negedge clk);
    check_vec("pulse_low", {31'b0, instruction_valid | read_write_valid}, 32'd0);
  endtask

  task automatic do_read(input bit is_fetch, input logic [31:0] addr, input logic [31:0] data,
                         input int ar_d, input int r_d, input int budget);
    if (is_fetch) begin
      pc       = addr;
      pc_valid = 1'b1;
    end else begin
      rw_addr     = addr;
      read_enable = 1'b1;
    end
    wait_ar("rd_ar_wait", budget);
    check_vec("rd_araddr", bus.araddr, addr);
    check_vec("rd_arprot", {29'b0, bus.arprot}, is_fetch ? 32'd4 : 32'd0);
    pc_valid    = 1'b0;
    read_enable = 1'b0;
    pc          = $urandom;
    rw_addr     = $urandom;
    push_exp(is_fetch, data);
    r_complete(is_fetch, addr, data, ar_d, r_d);
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_d, input int w_d, input int b_d);
    int n = 0;
    int c = 0;
    bit aw_done = 1'b0;
    bit w_done  = 1'b0;
    rw_addr      = addr;
    write_data   = data;
    write_strobe = strb;
    write_enable = 1'b1;
    while (!bus.awvalid && n < 4) begin
      @(negedge clk);
      n++;
    end
    check_vec("st_awvalid", {31'b0, bus.awvalid}, 32'd1);
    check_vec("st_wvalid", {31'b0, bus.wvalid}, 32'd1);
    check_vec("st_arvalid", {31'b0, bus.arvalid}, 32'd0);
    check_vec("st_awaddr", bus.awaddr, addr);
    check_vec("st_wdata", bus.wdata, data);
    check_vec("st_wstrb", {28'b0, bus.wstrb}, {28'b0, strb});
    check_vec("st_awprot", {29'b0, bus.awprot}, 32'd0);
    write_enable = 1'b0;
    read_enable  = 1'b0;
    pc_valid     = 1'b0;
    rw_addr      = $urandom;
    write_data   = $urandom;
    push_store();
    while (!(aw_done && w_done) && c < 16) begin
      bus.awready = !aw_done && (c >= aw_d);
      bus.wready  = !w_done && (c >= w_d);
      @(negedge clk);
      if (bus.awready) aw_done = 1'b1;
      if (bus.wready)  w_done  = 1'b1;
      bus.awready = 1'b0;
      bus.wready  = 1'b0;
      check_vec("aw_state", {31'b0, bus.awvalid}, {31'b0, !aw_done});
      check_vec("w_state", {31'b0, bus.wvalid}, {31'b0, !w_done});
      if (!(aw_done && w_done)) check_vec("b_early", {31'b0, bus.bready}, 32'd0);
      c++;
    end
    check_vec("bready_up", {31'b0, bus.bready}, 32'd1);
    for (int i = 0; i < b_d; i++) begin
      @(negedge clk);
      check_vec("bready_hold", {31'b0, bus.bready}, 32'd1);
    end
    bus.bvalid = 1'b1;
    bus.bresp  = 2'b00;
    @(negedge clk);
    bus.bvalid = 1'b0;
    check_vec("bready_drop", {31'b0, bus.bready}, 32'd0);
    check_vec("st_done_pulse", {31'b0, read_write_valid}, 32'd1);
    @(negedge clk);
    check_vec("st_pulse_low", {31'b0, read_write_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    n_vectors     = 0;
    n_miscompares = 0;
    model_rdata   = 32'd0;
    rst           = 1'b1;
    pc            = 32'd0;
    pc_valid      = 1'b0;
    rw_addr       = 32'd0;
    write_data    = 32'd0;
    read_enable   = 1'b0;
    write_enable  = 1'b0;
    write_strobe  = 4'd0;
    bus.awready   = 1'b0;
    bus.wready    = 1'b0;
    bus.bvalid    = 1'b0;
    bus.bresp     = 2'b00;
    bus.arready   = 1'b0;
    bus.rvalid    = 1'b0;
    bus.rdata     = 32'd0;
    bus.rresp     = 2'b00;

    repeat (2) @(negedge clk);
    check_vec("rst_arvalid", {31'b0, bus.arvalid}, 32'd0);
    check_vec("rst_awvalid", {31'b0, bus.awvalid}, 32'd0);
    check_vec("rst_wvalid", {31'b0, bus.wvalid}, 32'd0);
    check_vec("rst_bready", {31'b0, bus.bready}, 32'd0);
    check_vec("rst_rready", {31'b0, bus.rready}, 32'd0);
    check_vec("rst_iv", {31'b0, instruction_valid}, 32'd0);
    check_vec("rst_rwv", {31'b0, read_write_valid}, 32'd0);
    check_vec("rst_araddr", bus.araddr, 32'd0);
    check_vec("rst_arprot", {29'b0, bus.arprot}, 32'd0);
    check_vec("rst_awaddr", bus.awaddr, 32'd0);
    check_vec("rst_wdata", bus.wdata, 32'd0);
    check_vec("rst_instr", instruction, 32'd0);
    check_vec("rst_rdata", read_data, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Fetch: address must stay put while ARREADY is withheld and pc changes.
    do_read(1'b1, 32'habac, 32'hdeadaaaa, 1, 0, 2);
    do_read(1'b0, 32'h100, 32'h12345678, 0, 1, 2);
    check_vec("instr_hold", instruction, 32'hdeadaaaa);

    do_store(32'h200, 32'hcafef00d, 4'b0011, 0, 1, 0);
    do_store(32'h204, 32'h0badf00d, 4'b1100, 2, 0, 2);
    do_store(32'h208, 32'h55aa55aa, 4'b1111, 1, 1, 1);

    // Store wins over simultaneous load and fetch.
    read_enable = 1'b1;
    pc_valid    = 1'b1;
    pc          = 32'h600;
    do_store(32'h20c, 32'h13572468, 4'b0101, 0, 0, 0);

    // Load beats fetch; the still-held fetch starts only after DONE.
    pc          = 32'h500;
    rw_addr     = 32'h300;
    pc_valid    = 1'b1;
    read_enable = 1'b1;
    wait_ar("cont_ar1", 4);
    check_vec("cont_ar1_addr", bus.araddr, 32'h300);
    check_vec("cont_ar1_prot", {29'b0, bus.arprot}, 32'd0);
    read_enable = 1'b0;
    push_exp(1'b0, 32'h11112222);
    r_complete(1'b0, 32'h300, 32'h11112222, 0, 0);
    check_vec("cont_no_early_fetch", {31'b0, bus.arvalid}, 32'd0);
    wait_ar("cont_ar2", 4);
    check_vec("cont_ar2_addr", bus.araddr, 32'h500);
    check_vec("cont_ar2_prot", {29'b0, bus.arprot}, 32'd4);
    pc_valid = 1'b0;
    push_exp(1'b1, 32'h33334444);
    r_complete(1'b1, 32'h500, 32'h33334444, 1, 0);

    for (int i = 0; i < 12; i++) begin
      d = $urandom;
      case ($urandom_range(0, 2))
        0: do_read(1'b1, $urandom & 32'hffff_fffc, d, $urandom_range(0, 2), $urandom_range(0, 2), 4);
        1: do_read(1'b0, $urandom, d, $urandom_range(0, 2), $urandom_range(0, 2), 4);
        default: do_store($urandom, d, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                          $urandom_range(0, 3), $urandom_range(0, 2));
      endcase
    end

    // Abort: asynchronous reset while waiting in R.
    pc       = 32'h40;
    pc_valid = 1'b1;
    wait_ar("abort_ar", 4);
    pc_valid    = 1'b0;
    bus.arready = 1'b1;
    @(negedge clk);
    bus.arready = 1'b0;
    check_vec("abort_in_r", {31'b0, bus.rready}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check_vec("abort_rready", {31'b0, bus.rready}, 32'd0);
    check_vec("abort_arvalid", {31'b0, bus.arvalid}, 32'd0);
    check_vec("abort_instr", instruction, 32'd0);
    check_vec("abort_rdata", read_data, 32'd0);
    model_rdata = 32'd0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_read(1'b1, 32'h44, 32'h00c0ffee, 0, 0, 2);
    do_store(32'h210, 32'h89abcdef, 4'b1000, 1, 0, 0);

    repeat (3) @(negedge clk);
    check_vec("sb_drain", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
